// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues word addresses to a 1-cycle-latency memory and
// hands (inst, inst_pc) to decode through a 2-entry skid buffer with redirect squashing.
module instruction_fetch #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] imem_a,
    input  logic [31:0]       imem_rd,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid
);

    // Handshake: decode takes the head word in any cycle where inst_valid=1 and stall=0;
    // the word stays on inst/inst_pc until that happens. A redirect drops everything buffered.

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic [1:0]        count;
    logic [31:0]       tail_inst;
    logic [ADDR_W-1:0] tail_pc;

    logic              pop;
    logic              push;
    logic              issue;
    logic [2:0]        occupancy;
    logic [1:0]        remaining;

    assign inst_valid = (count != 2'd0);
    assign pop        = inst_valid & ~stall;
    assign push       = inflight & ~redirect;
    assign imem_a     = redirect ? redirect_pc : fetch_pc;
    assign remaining  = count - {1'b0, pop};

    // Slots the buffer will need once the in-flight word lands; only issue if one is still free.
    assign occupancy  = {1'b0, count} - {2'b00, pop} + {2'b00, inflight};
    assign issue      = redirect | (occupancy < 3'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            count       <= 2'd0;
            inst        <= 32'd0;
            inst_pc     <= '0;
            tail_inst   <= 32'd0;
            tail_pc     <= '0;
        end else begin
            if (issue) begin
                inflight    <= 1'b1;
                inflight_pc <= imem_a;
                fetch_pc    <= imem_a + PC_ONE;
            end else begin
                inflight    <= 1'b0;
            end

            if (redirect) begin
                count <= 2'd0;
            end else begin
                count <= remaining + {1'b0, push};
                if (pop) begin
                    inst    <= tail_inst;
                    inst_pc <= tail_pc;
                end
                // A push into an empty (or just-emptied) buffer lands directly in the head.
                if (push) begin
                    if (remaining == 2'd0) begin
                        inst    <= imem_rd;
                        inst_pc <= inflight_pc;
                    end else begin
                        tail_inst <= imem_rd;
                        tail_pc   <= inflight_pc;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, reset corner cases and randomized stall/redirect
// traffic checked against a queue-based model of the fetch stream.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, redirect;
    logic [15:0] redirect_pc;
    logic [15:0] imem_a;
    logic [31:0] imem_rd;
    logic [31:0] inst;
    logic [15:0] inst_pc;
    logic        inst_valid;

    logic        stall2, redirect2;
    logic [15:0] redirect_pc2;
    logic [15:0] imem_a2;
    logic [31:0] imem_rd2;
    logic [31:0] inst2;
    logic [15:0] inst_pc2;
    logic        inst_valid2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instruction_fetch #(.ADDR_W(16), .RESET_PC(16'h0000)) u_dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_a(imem_a), .imem_rd(imem_rd), .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid)
    );

    instruction_fetch #(.ADDR_W(16), .RESET_PC(16'hFFFE)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .stall(stall2), .redirect(redirect2), .redirect_pc(redirect_pc2),
        .imem_a(imem_a2), .imem_rd(imem_rd2), .inst(inst2), .inst_pc(inst_pc2), .inst_valid(inst_valid2)
    );

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return 32'h1000_0000 + {16'h0000, a};
    endfunction

    // Synchronous-read memories: word for the address seen at an edge appears after that edge.
    always @(posedge clk) begin
        imem_rd  <= mem_word(imem_a);
        imem_rd2 <= mem_word(imem_a2);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        stall;
        logic        redir;
        logic [15:0] rpc;
        logic        exp_valid;
        logic [15:0] exp_pc;
        logic [15:0] exp_a;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic s, input logic r, input logic [15:0] rpc,
                           input logic v, input logic [15:0] pc, input logic [15:0] a);
        vec_t e;
        e.stall = s; e.redir = r; e.rpc = rpc; e.exp_valid = v; e.exp_pc = pc; e.exp_a = a;
        vecs.push_back(e);
    endtask

    // Reference model: FIFO of delivered PCs, one outstanding memory request, next sequential PC.
    logic [15:0] m_q[$];
    logic        m_inflight;
    logic [15:0] m_inflight_pc;
    logic [15:0] m_fetch;

    task automatic model_reset();
        m_q.delete();
        m_inflight    = 1'b0;
        m_inflight_pc = 16'h0000;
        m_fetch       = 16'h0000;
    endtask

    task automatic model_step(input logic s, input logic r, input logic [15:0] rpc);
        int          held;
        logic        took;
        logic [15:0] addr;
        took = (m_q.size() != 0) && !s;
        held = m_q.size() - (took ? 1 : 0) + (m_inflight ? 1 : 0);
        addr = r ? rpc : m_fetch;
        if (r) begin
            m_q.delete();
        end else begin
            if (took) void'(m_q.pop_front());
            if (m_inflight) m_q.push_back(m_inflight_pc);
        end
        if (r || held < 2) begin
            m_inflight    = 1'b1;
            m_inflight_pc = addr;
            m_fetch       = addr + 16'd1;
        end else begin
            m_inflight = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
        stall2 = 1'b0; redirect2 = 1'b0; redirect_pc2 = 16'h0;

        // Directed table, cycle 0 = first cycle after reset release
        for (int c = 0; c < 4; c++)
            add_vec(1'b0, 1'b0, 16'h0, c >= 2, 16'(c - 2), 16'(c));
        for (int c = 4; c < 9; c++)
            add_vec(1'b1, 1'b0, 16'h0, 1'b1, 16'h0002, 16'h0004);
        add_vec(1'b0, 1'b0, 16'h0, 1'b1, 16'h0002, 16'h0004);
        for (int c = 10; c < 13; c++)
            add_vec(1'b0, 1'b0, 16'h0, 1'b1, 16'(c - 7), 16'(c - 5));
        add_vec(1'b0, 1'b1, 16'h0040, 1'b1, 16'h0006, 16'h0040);
        add_vec(1'b0, 1'b0, 16'h0,    1'b0, 16'h0000, 16'h0041);
        add_vec(1'b0, 1'b0, 16'h0,    1'b1, 16'h0040, 16'h0042);
        add_vec(1'b0, 1'b0, 16'h0,    1'b1, 16'h0041, 16'h0043);
        add_vec(1'b1, 1'b0, 16'h0,    1'b1, 16'h0042, 16'h0044);
        add_vec(1'b1, 1'b0, 16'h0,    1'b1, 16'h0042, 16'h0044);
        add_vec(1'b1, 1'b1, 16'h0080, 1'b1, 16'h0042, 16'h0080);
        add_vec(1'b0, 1'b0, 16'h0,    1'b0, 16'h0000, 16'h0081);
        add_vec(1'b0, 1'b0, 16'h0,    1'b1, 16'h0080, 16'h0082);
        add_vec(1'b0, 1'b0, 16'h0,    1'b1, 16'h0081, 16'h0083);
        add_vec(1'b0, 1'b1, 16'h0100, 1'b1, 16'h0082, 16'h0100);
        add_vec(1'b0, 1'b1, 16'h0200, 1'b0, 16'h0000, 16'h0200);
        add_vec(1'b0, 1'b0, 16'h0,    1'b0, 16'h0000, 16'h0201);
        add_vec(1'b0, 1'b0, 16'h0,    1'b1, 16'h0200, 16'h0202);
        add_vec(1'b0, 1'b0, 16'h0,    1'b1, 16'h0201, 16'h0203);

        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", {31'd0, inst_valid}, 32'd0);
        check("reset_inst", inst, 32'd0);
        check("reset_inst_pc", {16'd0, inst_pc}, 32'd0);
        check("reset_imem_a", {16'd0, imem_a}, 32'h0000);
        check("reset_imem_a_wrap", {16'd0, imem_a2}, 32'h0000_FFFE);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            stall = vecs[i].stall; redirect = vecs[i].redir; redirect_pc = vecs[i].rpc;
            #1;
            check($sformatf("vec%0d_valid", i), {31'd0, inst_valid}, {31'd0, vecs[i].exp_valid});
            check($sformatf("vec%0d_imem_a", i), {16'd0, imem_a}, {16'd0, vecs[i].exp_a});
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d_pc", i), {16'd0, inst_pc}, {16'd0, vecs[i].exp_pc});
                check($sformatf("vec%0d_inst", i), inst, mem_word(vecs[i].exp_pc));
            end
            if (i >= 2 && i <= 5) begin
                check($sformatf("wrap%0d_valid", i), {31'd0, inst_valid2}, 32'd1);
                check($sformatf("wrap%0d_pc", i), {16'd0, inst_pc2}, {16'd0, 16'hFFFE + 16'(i - 2)});
                check($sformatf("wrap%0d_inst", i), inst2, mem_word(16'hFFFE + 16'(i - 2)));
            end
            @(negedge clk);
        end

        // Fill the buffer under stall, then pull reset asynchronously mid-cycle
        stall = 1'b1; redirect = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("stalled_valid", {31'd0, inst_valid}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, inst_valid}, 32'd0);
        check("async_rst_inst_pc", {16'd0, inst_pc}, 32'd0);
        check("async_rst_inst", inst, 32'd0);
        check("async_rst_imem_a", {16'd0, imem_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Randomized traffic against the reference model, starting from RESET_PC refetch
        for (int c = 0; c < 800; c++) begin
            logic        s, r;
            logic [15:0] rpc;
            s   = (c < 3) ? 1'b0 : ($urandom_range(0, 99) < 30);
            r   = (c < 3) ? 1'b0 : ($urandom_range(0, 99) < 6);
            rpc = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3))
                                               : 16'($urandom_range(0, 16'hFFFF));
            stall = s; redirect = r; redirect_pc = rpc;
            #1;
            check("rand_imem_a", {16'd0, imem_a}, {16'd0, (r ? rpc : m_fetch)});
            check("rand_valid", {31'd0, inst_valid}, {31'd0, m_q.size() != 0});
            if (m_q.size() != 0) begin
                check("rand_pc", {16'd0, inst_pc}, {16'd0, m_q[0]});
                check("rand_inst", inst, mem_word(m_q[0]));
            end
            model_step(s, r, rpc);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
